// File: rtl/ledsrgb_pwm_core.sv
// RGB LED PWM engine fed by the ledsrgb register file. Config writes are staged
// and committed only at frame boundaries, with a prescaler and blink sequencer.
module ledsrgb_pwm_core #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PRESC_WIDTH        = 16,
  parameter int BLINK_WIDTH        = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_ctrl,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_color,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_prescale,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_blink,
  input  logic                          cfg_update,
  output logic                          cfg_pending,
  output logic                          frame_tick,
  output logic                          blink_phase,
  output logic                          led_r,
  output logic                          led_g,
  output logic                          led_b
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ON       = 2'd1,
    ST_OFF      = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]                    act_ctrl_q,  pend_ctrl_q;
  logic [23:0]                   act_color_q, pend_color_q;
  logic [PRESC_WIDTH-1:0]        act_presc_q, pend_presc_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] act_blink_q, pend_blink_q;
  logic                          pend_valid_q, pend_valid_d;

  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]             pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_WIDTH-1:0] phase_cnt_q, phase_cnt_d;
  logic [2:0]             led_q, led_d;

  logic                   running;
  logic                   tick;
  logic                   boundary;
  logic                   apply;
  logic [2:0]             eff_ctrl;
  logic [C_S_AXI_DATA_WIDTH-1:0] eff_blink;
  logic                   eff_en;
  logic                   eff_blink_en;
  logic [BLINK_WIDTH-1:0] eff_on_frames;
  logic [BLINK_WIDTH-1:0] eff_off_frames;
  logic [BLINK_WIDTH-1:0] phase_len;
  logic                   blink_changed;
  state_e                 entry_state;
  logic                   unused_bits;

  assign unused_bits = ^{cfg_ctrl[C_S_AXI_DATA_WIDTH-1:3],
                         cfg_color[C_S_AXI_DATA_WIDTH-1:24],
                         cfg_prescale[C_S_AXI_DATA_WIDTH-1:PRESC_WIDTH]};

  assign running  = (state_q != ST_DISABLED);
  assign tick     = (presc_cnt_q == act_presc_q);
  assign boundary = running && tick && (pwm_cnt_q == 8'hFF);
  // A disabled core has no frames to wait for, so a staged config lands at once.
  assign apply    = pend_valid_q && (boundary || !running);

  assign eff_ctrl       = apply ? pend_ctrl_q  : act_ctrl_q;
  assign eff_blink      = apply ? pend_blink_q : act_blink_q;
  assign eff_en         = eff_ctrl[0];
  assign eff_blink_en   = eff_ctrl[1];
  assign eff_on_frames  = eff_blink[BLINK_WIDTH-1:0];
  assign eff_off_frames = eff_blink[16 +: BLINK_WIDTH];
  assign phase_len      = (state_q == ST_ON) ? eff_on_frames : eff_off_frames;
  assign blink_changed  = (pend_blink_q != act_blink_q) || (pend_ctrl_q[1] != act_ctrl_q[1]);
  assign entry_state    = (eff_blink_en && (eff_on_frames == '0)) ? ST_OFF : ST_ON;

  assign pend_valid_d = cfg_update ? 1'b1 : (apply ? 1'b0 : pend_valid_q);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      act_ctrl_q   <= '0;
      act_color_q  <= '0;
      act_presc_q  <= '0;
      act_blink_q  <= '0;
      pend_ctrl_q  <= '0;
      pend_color_q <= '0;
      pend_presc_q <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (apply) begin
        act_ctrl_q  <= pend_ctrl_q;
        act_color_q <= pend_color_q;
        act_presc_q <= pend_presc_q;
        act_blink_q <= pend_blink_q;
      end
      if (cfg_update) begin
        pend_ctrl_q  <= cfg_ctrl[2:0];
        pend_color_q <= cfg_color[23:0];
        pend_presc_q <= cfg_prescale[PRESC_WIDTH-1:0];
        pend_blink_q <= cfg_blink;
      end
      pend_valid_q <= pend_valid_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_DISABLED;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      phase_cnt_q <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      led_q       <= led_d;
    end
  end

  // Phase sequencing only moves on frame boundaries; zero-length phases pin the state.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    case (state_q)
      ST_DISABLED: begin
        if (apply && eff_en) begin
          state_d     = entry_state;
          phase_cnt_d = '0;
        end
      end
      ST_ON, ST_OFF: begin
        if (boundary) begin
          phase_cnt_d = '0;
          if (!eff_en) begin
            state_d = ST_DISABLED;
          end else if (apply && blink_changed) begin
            state_d = entry_state;
          end else if (!eff_blink_en) begin
            state_d = ST_ON;
          end else if (eff_on_frames == '0) begin
            state_d = ST_OFF;
          end else if (eff_off_frames == '0) begin
            state_d = ST_ON;
          end else if (phase_cnt_q == phase_len - BLINK_WIDTH'(1)) begin
            state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
          end else begin
            phase_cnt_d = phase_cnt_q + BLINK_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d     = ST_DISABLED;
        phase_cnt_d = '0;
      end
    endcase

    if ((state_q == ST_DISABLED) || (state_d == ST_DISABLED)) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = pwm_cnt_q + 8'd1;
    end else begin
      presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
      pwm_cnt_d   = pwm_cnt_q;
    end
  end

  always_comb begin
    led_d[2] = ((state_q == ST_ON) && act_ctrl_q[0] && (pwm_cnt_q < act_color_q[23:16])) ^ act_ctrl_q[2];
    led_d[1] = ((state_q == ST_ON) && act_ctrl_q[0] && (pwm_cnt_q < act_color_q[15:8]))  ^ act_ctrl_q[2];
    led_d[0] = ((state_q == ST_ON) && act_ctrl_q[0] && (pwm_cnt_q < act_color_q[7:0]))   ^ act_ctrl_q[2];
    cfg_pending = pend_valid_q;
    frame_tick  = boundary;
    blink_phase = (state_q == ST_ON);
    led_r       = led_q[2];
    led_g       = led_q[1];
    led_b       = led_q[0];
  end

endmodule

// File: tb/tb_ledsrgb_pwm_core.sv
// Scoreboard bench for ledsrgb_pwm_core: a frame-position reference model
// predicts every output cycle by cycle while directed windows count duty cycles.
module tb_ledsrgb_pwm_core;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] cfgCtrl = '0, cfgColor = '0, cfgPrescale = '0, cfgBlink = '0;
  logic        cfgUpdate = 1'b0;
  logic        cfgPending, frameTick, blinkPhase, ledR, ledG, ledB;

  int passCount = 0;
  int checkCount = 0;

  ledsrgb_pwm_core dut (
    .ACLK(clk), .ARESETN(rstN),
    .cfg_ctrl(cfgCtrl), .cfg_color(cfgColor), .cfg_prescale(cfgPrescale), .cfg_blink(cfgBlink),
    .cfg_update(cfgUpdate), .cfg_pending(cfgPending), .frame_tick(frameTick),
    .blink_phase(blinkPhase), .led_r(ledR), .led_g(ledG), .led_b(ledB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] color;
    logic [31:0] presc;
    logic [31:0] blink;
  } cfg_t;

  // Reference model: position within the frame in clocks plus a frame-level phase tracker.
  cfg_t mAct, mPend;
  bit   mPendValid, mRunning, mPhaseOn;
  int   mPos, mFramesDone;
  logic [5:0] expQ[$];
  logic [5:0] monExp, monGot;
  int   cycleNo = 0;

  function automatic int frameLen(cfg_t c);
    return 256 * (int'(c.presc[15:0]) + 1);
  endfunction

  function automatic bit entryOn(cfg_t c);
    return !(c.ctrl[1] && (c.blink[15:0] == 16'd0));
  endfunction

  task automatic modelReset();
    mAct = '{default: '0};
    mPend = '{default: '0};
    mPendValid = 0; mRunning = 0; mPhaseOn = 0; mPos = 0; mFramesDone = 0;
  endtask

  task automatic advancePhase();
    int onF, offF;
    onF = int'(mAct.blink[15:0]);
    offF = int'(mAct.blink[31:16]);
    if (!mAct.ctrl[1]) begin mPhaseOn = 1; mFramesDone = 0; end
    else if (onF == 0) begin mPhaseOn = 0; mFramesDone = 0; end
    else if (offF == 0) begin mPhaseOn = 1; mFramesDone = 0; end
    else begin
      mFramesDone++;
      if (mFramesDone == (mPhaseOn ? onF : offF)) begin
        mPhaseOn = !mPhaseOn;
        mFramesDone = 0;
      end
    end
  endtask

  task automatic modelStep(output logic [5:0] expOut);
    logic [2:0] leds;
    int pw;
    bit onOk, changed;
    pw = mRunning ? mPos / (int'(mAct.presc[15:0]) + 1) : 0;
    onOk = mRunning && mPhaseOn;
    leds[2] = (onOk && (pw < int'(mAct.color[23:16]))) ^ mAct.ctrl[2];
    leds[1] = (onOk && (pw < int'(mAct.color[15:8])))  ^ mAct.ctrl[2];
    leds[0] = (onOk && (pw < int'(mAct.color[7:0])))   ^ mAct.ctrl[2];
    if (!mRunning) begin
      if (mPendValid) begin
        mAct = mPend;
        mPendValid = 0;
        if (mAct.ctrl[0]) begin
          mRunning = 1; mPos = 0; mFramesDone = 0; mPhaseOn = entryOn(mAct);
        end
      end
    end else if (mPos == frameLen(mAct) - 1) begin
      changed = 0;
      mPos = 0;
      if (mPendValid) begin
        changed = (mPend.blink != mAct.blink) || (mPend.ctrl[1] != mAct.ctrl[1]);
        mAct = mPend;
        mPendValid = 0;
      end
      if (!mAct.ctrl[0]) begin mRunning = 0; mPhaseOn = 0; mFramesDone = 0; end
      else if (changed) begin mPhaseOn = entryOn(mAct); mFramesDone = 0; end
      else advancePhase();
    end else begin
      mPos++;
    end
    if (cfgUpdate) begin
      mPend = '{cfgCtrl, cfgColor, cfgPrescale, cfgBlink};
      mPendValid = 1;
    end
    expOut = {mPendValid, mRunning && (mPos == frameLen(mAct) - 1), mRunning && mPhaseOn, leds};
  endtask

  // Model process: one expected vector per clock, replaced when reset strikes mid-cycle.
  initial begin
    logic [5:0] e;
    modelReset();
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        modelReset();
        if (expQ.size() > 0) void'(expQ.pop_back());
        expQ.push_back(6'b0);
      end else begin
        modelStep(e);
        expQ.push_back(e);
      end
    end
  end

  // Monitor process: pops the prediction for this cycle and compares against the pins.
  initial begin
    forever begin
      @(negedge clk);
      cycleNo++;
      if (expQ.size() > 0) begin
        monExp = expQ.pop_front();
        monGot = {cfgPending, frameTick, blinkPhase, ledR, ledG, ledB};
        checkCount++;
        if (monGot === monExp) passCount++;
        else $display("[TB] FAIL scoreboard cycle %0d: got %b expected %b (pend,ftick,phase,r,g,b)",
                      cycleNo, monGot, monExp);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] c, input logic [31:0] col,
                               input logic [31:0] p, input logic [31:0] b);
    @(posedge clk); #1;
    cfgCtrl = c; cfgColor = col; cfgPrescale = p; cfgBlink = b; cfgUpdate = 1'b1;
    @(posedge clk); #1;
    cfgUpdate = 1'b0;
    cfgCtrl = $urandom; cfgColor = $urandom; cfgPrescale = $urandom; cfgBlink = $urandom;
  endtask

  task automatic waitApplied(input string name, input int limit);
    int n = 0;
    while (mPendValid && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (mPendValid) begin
      checkCount++;
      $display("[TB] FAIL %s: apply not seen within %0d cycles, required within bound", name, limit);
    end
  endtask

  task automatic waitModelPos(input string name, input int target, input int limit);
    int n = 0;
    while (!(mRunning && mPos == target) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(mRunning && mPos == target)) begin
      checkCount++;
      $display("[TB] FAIL %s: position %0d not reached within %0d cycles", name, target, limit);
    end
  endtask

  // Skips the sample still showing the previous frame, then counts highs per output.
  task automatic countWindow(input int cycles, output int r, output int g, output int b,
                             output int ph, output int ft);
    r = 0; g = 0; b = 0; ph = 0; ft = 0;
    @(negedge clk);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      r += int'(ledR); g += int'(ledG); b += int'(ledB);
      ph += int'(blinkPhase); ft += int'(frameTick);
    end
  endtask

  initial begin
    int r, g, b, ph, ft;
    logic [31:0] c, col, p, bl;

    repeat (4) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(32'h1, 32'h0040_0000, 32'h0, 32'h0);
    waitApplied("t1_apply", 8);
    countWindow(256, r, g, b, ph, ft);
    checkOutput("t1_red_high", r, 64);
    checkOutput("t1_green_high", g, 0);
    checkOutput("t1_blue_high", b, 0);
    checkOutput("t1_frame_ticks", ft, 1);

    waitModelPos("t2_align", 99, 600);
    applyStimulus(32'h1, 32'h00C0_0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("t2_pending_held", int'(cfgPending), 1);
    waitApplied("t2_apply", 400);
    countWindow(256, r, g, b, ph, ft);
    checkOutput("t2_red_high", r, 192);

    applyStimulus(32'h5, 32'h0000_00FF, 32'h0, 32'h0);
    waitApplied("t3_apply", 400);
    countWindow(256, r, g, b, ph, ft);
    checkOutput("t3_blue_high", b, 1);
    checkOutput("t3_red_high", r, 256);
    checkOutput("t3_green_high", g, 256);

    applyStimulus(32'h3, 32'h00FF_FFFF, 32'h3, 32'h0001_0002);
    waitApplied("t4_apply", 400);
    countWindow(3072, r, g, b, ph, ft);
    checkOutput("t4_phase_on", ph, 2048);
    checkOutput("t4_frame_ticks", ft, 3);
    checkOutput("t4_red_high", r, 2040);

    applyStimulus(32'h1, 32'h0000_0010, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    applyStimulus(32'h1, 32'h0000_0020, 32'h0, 32'h0);
    waitApplied("t5_apply", 1200);
    @(negedge clk);
    checkOutput("t5_pending_clear", int'(cfgPending), 0);
    countWindow(256, r, g, b, ph, ft);
    checkOutput("t5_blue_high", b, 32);

    applyStimulus(32'h1, 32'h00FF_0000, 32'h0, 32'h0);
    waitApplied("t6_apply", 400);
    repeat (20) @(posedge clk);
    applyStimulus(32'h1, 32'h0012_3456, 32'h0, 32'h0);
    #2;
    checkOutput("t6_red_before_reset", int'(ledR), 1);
    rstN = 1'b0;
    #1;
    checkOutput("t6_red_in_reset", int'(ledR), 0);
    checkOutput("t6_pending_in_reset", int'(cfgPending), 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    countWindow(300, r, g, b, ph, ft);
    checkOutput("t6_quiet_after_reset", r + g + b + ph + ft + int'(cfgPending), 0);

    for (int i = 0; i < 14; i++) begin
      c = $urandom;
      c[0] = ($urandom_range(0, 4) != 0);
      col = $urandom;
      p = $urandom;
      p[15:0] = 16'($urandom_range(0, 3));
      bl = $urandom;
      bl[15:0] = 16'($urandom_range(0, 3));
      bl[31:16] = 16'($urandom_range(0, 3));
      applyStimulus(c, col, p, bl);
      if (i % 3 == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        col = $urandom;
        applyStimulus(c, col, p, bl);
      end
      repeat ($urandom_range(100, 1500)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ledsrgb_pwm_core.md
Name: ledsrgb_pwm_core

Overview:
Consumes the four 32-bit slave registers of the ledsrgb AXI4-Lite IP (ctrl, color, prescale, blink) and drives three PWM outputs for an RGB LED. It is the stage directly downstream of the register file. Register writes are captured on an update strobe and applied only at PWM frame boundaries, so colour changes never glitch mid-frame. It adds a prescaler and a blink on/off phase sequencer.

Parameters:
C_S_AXI_DATA_WIDTH, 32, width of each register input; only 32 is supported.
PRESC_WIDTH, 16, prescaler width; taken from cfg_prescale[PRESC_WIDTH-1:0].
BLINK_WIDTH, 16, width of each blink phase count.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous, active-low reset.
cfg_ctrl  in  32  bit0 enable, bit1 blink_en, bit2 invert; other bits ignored.
cfg_color  in  32  [23:16] R duty, [15:8] G duty, [7:0] B duty.
cfg_prescale  in  32  tick divisor; one tick every (value+1) clocks.
cfg_blink  in  32  [15:0] on_frames, [31:16] off_frames.
cfg_update  in  1  one-cycle pulse: capture all cfg_* into the pending set.
cfg_pending  out  1  high while a captured config awaits application.
frame_tick  out  1  one-cycle pulse on each frame boundary.
blink_phase  out  1  1 = ON phase, 0 = OFF phase.
led_r, led_g, led_b  out  1 each  PWM outputs, registered.

Behaviour:
- Reset (ARESETN low, asynchronous): all active and pending config = 0, counters = 0, state DISABLED, cfg_pending = 0, frame_tick = 0, blink_phase = 0, led_* = 0.
- Prescaler: presc_cnt counts 0..P, where P = active prescale. tick = (presc_cnt == P). With P = 0, tick is asserted every clock.
- PWM counter: pwm_cnt is 8 bits and advances on tick. It wraps 255->0. The frame boundary is the tick with pwm_cnt == 255. frame_tick pulses in the same cycle that pwm_cnt wraps.
- Raw PWM per channel: on = (pwm_cnt < duty) & phase_on & enable.
  - duty 0: always off.
  - duty 255: on for 255 of 256 ticks.
- Output: led_x <= on XOR invert. This is registered, so there is 1 clock of latency from pwm_cnt to the pin.
- Capture: cfg_update latches all four inputs into the pending set and sets cfg_pending.
  - A further cfg_update before application overwrites the pending set; only the last one is kept.
- Apply, while enabled: the pending set is copied to active on the frame boundary and cfg_pending clears.
  - If cfg_update coincides with a frame boundary, the new values are captured and become pending. They apply at the next boundary; the old pending set is applied now.
- Apply, while DISABLED: the pending set is applied on the cycle after capture, with no frame wait.
  - When the applied config has enable=1: presc_cnt, pwm_cnt and phase counters restart from 0, and the state becomes ON.
- State machine (transitions are evaluated only on frame boundaries, except the DISABLED exit):
  - DISABLED: led_* = invert. Exits on apply with enable=1 to ON.
  - ON: blink_phase = 1. phase_cnt counts frames.
    - blink_en=0: stay in ON.
    - blink_en=1 and phase_cnt == on_frames-1: go to OFF and clear phase_cnt.
  - OFF: blink_phase = 0, outputs inactive. When phase_cnt == off_frames-1: go to ON and clear phase_cnt.
  - Active enable=0 at any boundary: go to DISABLED and clear counters.
- Zero-length phases, with blink_en=1:
  - on_frames = 0: the ON phase is skipped; stay in OFF.
  - off_frames = 0: stay in ON.
  - Both 0: stay in OFF.
- Entry after apply: if blink_en=1 and on_frames=0, the block enters OFF instead of ON.
- A new config applied at a boundary does not reset phase_cnt or the current phase unless enable toggles or the blink fields change. If the blink fields change, phase_cnt clears and the state re-enters ON.
- Asserting reset mid-frame immediately forces every output to its reset value. Resumption requires a new cfg_update.

Test Plan:
- Reset released, then ctrl=0x1, color=0x00400000, prescale=0, blink=0, update -> after a 1-cycle apply, led_r is high for 64 of every 256 clocks. led_g and led_b stay 0. frame_tick has a period of 256 clocks.
- While running, color changed to 0x00C00000 with update at pwm_cnt=100 -> the current frame keeps 64 high clocks. cfg_pending stays high until the boundary. The next frame has 192 high clocks.
- ctrl=0x5 (invert), color=0x000000FF -> led_b is low for 255 clocks and high for 1 clock per frame. led_r and led_g are constant 1.
- ctrl=0x3, blink=0x00010002, color=0x00FFFFFF, prescale=3 -> each frame is 1024 clocks. The pattern repeats: 2 frames with blink_phase=1 and PWM active, then 1 frame with all LEDs 0.
- Two cfg_update pulses within one frame (color 0x10, then 0x20 on B) -> only 0x20 is applied at the boundary.
- ARESETN pulled low mid-frame with led_r high -> led_r=0 asynchronously and cfg_pending=0. After release, outputs stay 0 until the next update.
